// File: rtl/if_id_hazard_responder_if.sv
// Stall/Flush handshake bundle between the hazard detection unit and the IF/ID responder.
// Optional statistics signals appear when HAZARD_STATS_EN is defined.
// Handshake: Stall/Flush are level requests sampled on every rising clk edge.
// They have no valid/ready pair and need no acknowledge. PCWrite is the only back-pressure signal toward fetch.
interface if_id_hazard_responder_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16
);
    logic              Stall;
    logic              Flush;
    logic [DATA_W-1:0] IF_PC_Plus4;
    logic [DATA_W-1:0] IF_Instruction;
    logic [CTRL_W-1:0] ID_Control;
    logic              PCWrite;
    logic [DATA_W-1:0] IF_ID_PC_Plus4;
    logic [DATA_W-1:0] IF_ID_Instruction;
    logic              IF_ID_Valid;
    logic [CTRL_W-1:0] ID_EX_Control;
    logic              StallTimeout;
`ifdef HAZARD_STATS_EN
    logic [31:0]       StallCount;
    logic [31:0]       FlushCount;

    modport master (
        output Stall, Flush, IF_PC_Plus4, IF_Instruction, ID_Control,
        input  PCWrite, IF_ID_PC_Plus4, IF_ID_Instruction, IF_ID_Valid,
               ID_EX_Control, StallTimeout, StallCount, FlushCount
    );
    modport slave (
        input  Stall, Flush, IF_PC_Plus4, IF_Instruction, ID_Control,
        output PCWrite, IF_ID_PC_Plus4, IF_ID_Instruction, IF_ID_Valid,
               ID_EX_Control, StallTimeout, StallCount, FlushCount
    );
`else
    modport master (
        output Stall, Flush, IF_PC_Plus4, IF_Instruction, ID_Control,
        input  PCWrite, IF_ID_PC_Plus4, IF_ID_Instruction, IF_ID_Valid,
               ID_EX_Control, StallTimeout
    );
    modport slave (
        input  Stall, Flush, IF_PC_Plus4, IF_Instruction, ID_Control,
        output PCWrite, IF_ID_PC_Plus4, IF_ID_Instruction, IF_ID_Valid,
               ID_EX_Control, StallTimeout
    );
`endif
endinterface

// File: rtl/if_id_hazard_responder.sv
// IF/ID pipeline register with stall hold, multi-cycle flush bubbles, and runaway-stall detection.
// When HAZARD_STATS_EN is defined, it adds the StallCount/FlushCount statistics counters.
// DebugState exposes the RUN/STALL/FLUSH state: 0=RUN, 1=STALL, 2=FLUSH.
module if_id_hazard_responder #(
    parameter int DATA_W       = 32,
    parameter int CTRL_W       = 16,
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_STALL    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    if_id_hazard_responder_if.slave   hz,
    output logic [1:0]                DebugState
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] STALL_LIMIT  = 8'(MAX_STALL);

    state_t            state;
    logic [3:0]        flushCnt;
    logic [7:0]        stallCnt;
    logic [7:0]        stallNext;
    logic [DATA_W-1:0] pcReg;
    logic [DATA_W-1:0] instrReg;
    logic              validReg;
    logic              timeoutReg;
    logic              stallActive;

    // A stall only takes effect when no flush is requested and no bubble train is running.
    always_comb begin
        stallActive = hz.Stall && !hz.Flush && (state != FLUSH);
        stallNext   = 8'd1;
        if (state == STALL) begin
            stallNext = (stallCnt == 8'hFF) ? 8'hFF : stallCnt + 8'd1;
        end
    end

    // The state machine updates the IF/ID register and the stall/flush counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            flushCnt   <= 4'd0;
            stallCnt   <= 8'd0;
            pcReg      <= '0;
            instrReg   <= '0;
            validReg   <= 1'b0;
            timeoutReg <= 1'b0;
        end else if (hz.Flush) begin
            pcReg    <= '0;
            instrReg <= '0;
            validReg <= 1'b0;
            flushCnt <= FLUSH_RELOAD;
            stallCnt <= 8'd0;
            state    <= (FLUSH_RELOAD != 4'd0) ? FLUSH : RUN;
        end else begin
            case (state)
                FLUSH: begin
                    pcReg    <= '0;
                    instrReg <= '0;
                    validReg <= 1'b0;
                    flushCnt <= flushCnt - 4'd1;
                    if (flushCnt <= 4'd1) begin
                        state <= RUN;
                    end
                end
                STALL, RUN: begin
                    if (hz.Stall) begin
                        state    <= STALL;
                        stallCnt <= stallNext;
                        if (stallNext >= STALL_LIMIT) begin
                            timeoutReg <= 1'b1;
                        end
                    end else begin
                        state    <= RUN;
                        stallCnt <= 8'd0;
                        pcReg    <= hz.IF_PC_Plus4;
                        instrReg <= hz.IF_Instruction;
                        validReg <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    // Statistics: count cycles frozen by a stall and count accepted flush requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            hz.StallCount <= 32'd0;
            hz.FlushCount <= 32'd0;
        end else begin
            if (stallActive) hz.StallCount <= hz.StallCount + 32'd1;
            if (hz.Flush)    hz.FlushCount <= hz.FlushCount + 32'd1;
        end
    end
`endif

    // Drive the outputs: PCWrite and the ID/EX bubble mux are combinational on the current request.
    always_comb begin
        hz.PCWrite           = !reset && !stallActive;
        hz.ID_EX_Control     = (reset || !validReg || stallActive) ? '0 : hz.ID_Control;
        hz.IF_ID_PC_Plus4    = pcReg;
        hz.IF_ID_Instruction = instrReg;
        hz.IF_ID_Valid       = validReg;
        hz.StallTimeout      = timeoutReg;
        DebugState           = state;
    end
endmodule

// File: tb/tb_if_id_hazard_responder.sv
// Self-checking bench for if_id_hazard_responder with FLUSH_CYCLES=2 and MAX_STALL=8.
// The bench runs directed steps and then random steps.
// A reference model tracks the remaining bubble count and the stall run length.
module tb_if_id_hazard_responder;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int FC = 2;
    localparam int MS = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbgState;
    int         nCmp = 0;
    int         nErr = 0;

    if_id_hazard_responder_if #(.DATA_W(DW), .CTRL_W(CW)) hz ();

    if_id_hazard_responder #(
        .DATA_W(DW), .CTRL_W(CW), .FLUSH_CYCLES(FC), .MAX_STALL(MS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hz         (hz),
        .DebugState (dbgState)
    );

    // Clock and reset block.
    always #5 clk = ~clk;

    // Reference model state.
    logic [DW-1:0] mPc = '0;
    logic [DW-1:0] mInstr = '0;
    logic          mValid = 1'b0;
    int            mBubbles = 0;
    int            mStallRun = 0;
    logic          mTimeout = 1'b0;
    logic [31:0]   mStallCnt = 32'd0;
    logic [31:0]   mFlushCnt = 32'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each step drives one cycle of inputs and checks the combinational outputs before the edge.
    // It then advances the model and checks the registered outputs after the edge.
    task automatic step(input logic r, input logic s, input logic f,
                        input logic [DW-1:0] pc, input logic [DW-1:0] ins,
                        input logic [CW-1:0] ctl);
        logic frozen;
        @(negedge clk);
        reset             = r;
        hz.Stall          = s;
        hz.Flush          = f;
        hz.IF_PC_Plus4    = pc;
        hz.IF_Instruction = ins;
        hz.ID_Control     = ctl;
        #1;
        frozen = !r && s && !f && (mBubbles == 0);
        chk("PCWrite", 64'(hz.PCWrite), 64'(!r && !frozen));
        chk("ID_EX_Control", 64'(hz.ID_EX_Control),
            64'((r || !mValid || frozen) ? '0 : ctl));
        @(posedge clk);
        if (r) begin
            mPc = '0; mInstr = '0; mValid = 1'b0;
            mBubbles = 0; mStallRun = 0; mTimeout = 1'b0;
            mStallCnt = 32'd0; mFlushCnt = 32'd0;
        end else if (f) begin
            mPc = '0; mInstr = '0; mValid = 1'b0;
            mBubbles = FC - 1; mStallRun = 0;
            mFlushCnt = mFlushCnt + 32'd1;
        end else if (mBubbles > 0) begin
            mPc = '0; mInstr = '0; mValid = 1'b0;
            mBubbles = mBubbles - 1;
        end else if (s) begin
            mStallRun = (mStallRun >= 255) ? 255 : mStallRun + 1;
            if (mStallRun >= MS) mTimeout = 1'b1;
            mStallCnt = mStallCnt + 32'd1;
        end else begin
            mPc = pc; mInstr = ins; mValid = 1'b1; mStallRun = 0;
        end
        #1;
        chk("IF_ID_PC_Plus4", 64'(hz.IF_ID_PC_Plus4), 64'(mPc));
        chk("IF_ID_Instruction", 64'(hz.IF_ID_Instruction), 64'(mInstr));
        chk("IF_ID_Valid", 64'(hz.IF_ID_Valid), 64'(mValid));
        chk("StallTimeout", 64'(hz.StallTimeout), 64'(mTimeout));
`ifdef HAZARD_STATS_EN
        chk("StallCount", 64'(hz.StallCount), 64'(mStallCnt));
        chk("FlushCount", 64'(hz.FlushCount), 64'(mFlushCnt));
`endif
    endtask

    initial begin
        hz.Stall = 1'b0;
        hz.Flush = 1'b0;
        hz.IF_PC_Plus4 = '0;
        hz.IF_Instruction = '0;
        hz.ID_Control = '0;

        // Hold reset for three cycles while a load word is presented at fetch.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h4, 32'h8C220004, 16'hA5A5);
        chk("reset_valid", 64'(hz.IF_ID_Valid), 64'd0);
        step(1'b0, 1'b0, 1'b0, 32'h4, 32'h8C220004, 16'hA5A5);
        chk("first_load_instr", 64'(hz.IF_ID_Instruction), 64'h8C220004);
        chk("first_load_valid", 64'(hz.IF_ID_Valid), 64'd1);

        // A two-cycle stall must hold IF/ID; the release cycle loads the current fetch.
        step(1'b0, 1'b0, 1'b0, 32'hC, 32'h00000020, 16'h0011);
        step(1'b0, 1'b1, 1'b0, 32'h10, 32'h11111111, 16'h0022);
        step(1'b0, 1'b1, 1'b0, 32'h14, 32'h22222222, 16'h0022);
        chk("stall_hold_pc", 64'(hz.IF_ID_PC_Plus4), 64'hC);
        step(1'b0, 1'b0, 1'b0, 32'h14, 32'h22222222, 16'h0022);
        chk("stall_release_pc", 64'(hz.IF_ID_PC_Plus4), 64'h14);

        // A single flush request must produce two bubbles.
        step(1'b0, 1'b0, 1'b1, 32'h18, 32'h33333333, 16'h0F0F);
        step(1'b0, 1'b0, 1'b0, 32'h1C, 32'h44444444, 16'h0F0F);
        chk("flush_bubble2_valid", 64'(hz.IF_ID_Valid), 64'd0);
        step(1'b0, 1'b0, 1'b0, 32'h20, 32'h55555555, 16'h0F0F);

        // When Stall and Flush arrive together, the flush wins.
        step(1'b0, 1'b1, 1'b1, 32'h24, 32'h66666666, 16'h1234);
        step(1'b0, 1'b1, 1'b0, 32'h28, 32'h77777777, 16'h1234);
        step(1'b0, 1'b0, 1'b0, 32'h2C, 32'h88888888, 16'h1234);

        // Hold a stall for eight cycles; StallTimeout must be sticky after the stall drops.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 32'h30, 32'h99999999, 16'h4321);
        chk("timeout_8th_edge", 64'(hz.StallTimeout), 64'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h34 + 32'(4 * i), 32'hABCD0000 + 32'(i), 16'h4321);
        chk("timeout_sticky", 64'(hz.StallTimeout), 64'd1);
        step(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 16'h0);
        chk("timeout_cleared", 64'(hz.StallTimeout), 64'd0);

        // Run three stall cycles and two flushes, then reset.
        step(1'b0, 1'b0, 1'b0, 32'h44, 32'hDEADBEEF, 16'h0001);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h48, 32'h1, 16'h0002);
        step(1'b0, 1'b0, 1'b1, 32'h4C, 32'h2, 16'h0003);
        step(1'b0, 1'b0, 1'b1, 32'h50, 32'h3, 16'h0004);
        step(1'b0, 1'b0, 1'b0, 32'h54, 32'h4, 16'h0005);
        step(1'b1, 1'b0, 1'b0, 32'h58, 32'h5, 16'h0006);

        // Random traffic, with occasional mid-stall and mid-flush resets.
        for (int i = 0; i < 400; i++) begin
            logic r, s, f;
            r = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 99) < 45);
            f = ($urandom_range(0, 99) < 12);
            step(r, s, f, $urandom, $urandom, 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
